// File: rtl/result_writer.sv
// Drains a result BRAM to SDRAM through an Avalon write-burst master.
// Each BRAM line becomes one burst of LINE_N beats. Beat 0 carries the low bits of the line.
module result_writer #(
  parameter int BRAM_W  = 256,
  parameter int BRAM_L  = 16,
  parameter int SDRAM_W = 128,
  localparam int AW     = (BRAM_L > 1) ? $clog2(BRAM_L) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        base_addr,
  output logic [AW-1:0]      ram_addr,
  output logic               ram_re,
  input  logic [BRAM_W-1:0]  ram_q,
  output logic [31:0]        write_addr,
  output logic [10:0]        write_cnt,
  output logic               write_start,
  output logic [SDRAM_W-1:0] write_data,
  output logic               write_valid,
  input  logic               write_accept,
  input  logic               write_burst_done,
  output logic               busy,
  output logic               done
);

  localparam int LINE_N = (BRAM_W + SDRAM_W - 1) / SDRAM_W;
  localparam int BUF_W  = LINE_N * SDRAM_W;
  localparam int BEAT_W = (LINE_N > 1) ? $clog2(LINE_N) : 1;
  localparam logic [31:0]     STRIDE    = 32'(LINE_N * (SDRAM_W / 8));
  localparam logic [AW-1:0]   LAST_LINE = AW'(BRAM_L - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_N - 1);

  // state     | meaning
  // IDLE      | waiting for start
  // RD_LINE   | BRAM read issued for line_cnt
  // WAIT_Q    | BRAM data returns, captured into line buffer
  // SEND_ADDR | burst request with address and length
  // SEND_BLK  | streaming beats, advancing on accept
  // WAIT_ACK  | waiting for the master to close the burst
  typedef enum logic [2:0] {
    IDLE,
    RD_LINE,
    WAIT_Q,
    SEND_ADDR,
    SEND_BLK,
    WAIT_ACK
  } state_t;

  state_t                          state;
  logic [AW-1:0]                   line_cnt;
  logic [BEAT_W-1:0]               beat_cnt;
  logic [LINE_N-1:0][SDRAM_W-1:0]  line_buf;

  // Beat mux: the line buffer is zero-padded, so the top beat carries zeros above BRAM_W.
  assign write_data = line_buf[beat_cnt];
  assign busy       = (state != IDLE);

  // Sequencer; outputs are registered and set on entry to the state that owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      line_cnt    <= '0;
      beat_cnt    <= '0;
      line_buf    <= '0;
      ram_addr    <= '0;
      ram_re      <= 1'b0;
      write_addr  <= '0;
      write_cnt   <= '0;
      write_start <= 1'b0;
      write_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            write_addr <= base_addr;
            line_cnt   <= '0;
            ram_addr   <= '0;
            ram_re     <= 1'b1;
            done       <= 1'b0;
            state      <= RD_LINE;
          end
        end
        RD_LINE: begin
          ram_re <= 1'b0;
          state  <= WAIT_Q;
        end
        WAIT_Q: begin
          line_buf    <= BUF_W'(ram_q);
          beat_cnt    <= '0;
          write_cnt   <= 11'(LINE_N);
          write_start <= 1'b1;
          state       <= SEND_ADDR;
        end
        SEND_ADDR: begin
          write_start <= 1'b0;
          write_valid <= 1'b1;
          state       <= SEND_BLK;
        end
        SEND_BLK: begin
          if (write_accept) begin
            if (beat_cnt == LAST_BEAT) begin
              write_valid <= 1'b0;
              state       <= WAIT_ACK;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        WAIT_ACK: begin
          if (write_burst_done) begin
            if (line_cnt == LAST_LINE) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              line_cnt   <= line_cnt + 1'b1;
              ram_addr   <= line_cnt + 1'b1;
              ram_re     <= 1'b1;
              write_addr <= write_addr + STRIDE;
              state      <= RD_LINE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_writer.sv
// Bench for result_writer: three instances (BRAM_W 256/200/128, SDRAM_W 128, BRAM_L 16)
// compared against a queue model of expected bursts and beats.
module tb_result_writer;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        accept;
  logic [31:0] base_addr;

  logic [31:0]  waddr  [NI];
  logic [10:0]  wcnt   [NI];
  logic         wstart [NI];
  logic         wvalid [NI];
  logic [127:0] wdata  [NI];
  logic         busy   [NI];
  logic         done   [NI];
  logic         rre    [NI];
  logic [3:0]   raddr  [NI];
  logic         bdone  [NI];

  logic [255:0] mem [16];

  int nchk = 0;
  int nerr = 0;

  logic [31:0]  exp_a [NI][$];
  logic [127:0] exp_d [NI][$];
  int           bursts [NI];
  int           beats  [NI];
  int           left   [NI];
  int           rises  [NI];
  bit           pend   [NI];
  bit           held   [NI];
  bit           done_q [NI];
  logic [127:0] held_d [NI];
  bit           rand_acc = 1'b0;

  function automatic int bw_of(input int g);
    return (g == 0) ? 256 : (g == 1) ? 200 : 128;
  endfunction

  function automatic int ln_of(input int g);
    return (bw_of(g) + 127) / 128;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int BW = (g == 0) ? 256 : (g == 1) ? 200 : 128;
    logic [BW-1:0] q;
    result_writer #(.BRAM_W(BW), .BRAM_L(16), .SDRAM_W(128)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .base_addr        (base_addr),
      .ram_addr         (raddr[g]),
      .ram_re           (rre[g]),
      .ram_q            (q),
      .write_addr       (waddr[g]),
      .write_cnt        (wcnt[g]),
      .write_start      (wstart[g]),
      .write_data       (wdata[g]),
      .write_valid      (wvalid[g]),
      .write_accept     (accept),
      .write_burst_done (bdone[g]),
      .busy             (busy[g]),
      .done             (done[g])
    );
    // BRAM model: one-cycle read latency
    always @(posedge clk) if (rre[g]) q <= mem[raddr[g]][BW-1:0];
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stream: every line truncated to BRAM_W, cut into 128-bit beats, low beat first.
  task automatic build(input int g, input logic [31:0] base);
    logic [255:0] mask;
    logic [255:0] line;
    int ln;
    ln   = ln_of(g);
    mask = (256'(1) << bw_of(g)) - 256'(1);
    exp_a[g].delete();
    exp_d[g].delete();
    for (int k = 0; k < 16; k++) begin
      line = mem[k] & mask;
      exp_a[g].push_back(base + 32'(k * ln * 16));
      for (int b = 0; b < ln; b++) exp_d[g].push_back(128'(line >> (128 * b)));
    end
  endtask

  task automatic check_reset(input int g);
    check("rst_write_addr", waddr[g], 0);
    check("rst_write_cnt", wcnt[g], 0);
    check("rst_write_start", wstart[g], 0);
    check("rst_write_valid", wvalid[g], 0);
    check("rst_write_data", wdata[g], 0);
    check("rst_busy", busy[g], 0);
    check("rst_done", done[g], 0);
    check("rst_ram_re", rre[g], 0);
    check("rst_ram_addr", raddr[g], 0);
  endtask

  task automatic launch(input logic [31:0] base);
    for (int g = 0; g < NI; g++) begin
      build(g, base);
      bursts[g] = 0;
      beats[g]  = 0;
      rises[g]  = 0;
      held[g]   = 1'b0;
    end
    @(posedge clk); #1;
    base_addr = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    for (int g = 0; g < NI; g++) begin
      check("done_cleared", done[g], 0);
      check("busy_after_start", busy[g], 1);
      check("first_ram_re", rre[g], 1);
      check("first_ram_addr", raddr[g], 0);
    end
  endtask

  task automatic wait_all();
    int n;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    #2;
    for (int g = 0; g < NI; g++) begin
      check("done_set", done[g], 1);
      check("burst_count", bursts[g], 16);
      check("beat_count", beats[g], 16 * ln_of(g));
      check("done_rises", rises[g], 1);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 16; k++)
      for (int w = 0; w < 8; w++) mem[k][32*w +: 32] = $urandom;
  endtask

  // Burst/beat monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < NI; g++) begin
        if (wstart[g]) begin
          check("burst_expected", exp_a[g].size() > 0, 1'b1);
          if (exp_a[g].size() > 0) check("write_addr", waddr[g], exp_a[g].pop_front());
          check("write_cnt", wcnt[g], ln_of(g));
          bursts[g]++;
          left[g] = ln_of(g);
        end
        if (wvalid[g]) begin
          if (held[g]) check("data_hold", wdata[g], held_d[g]);
          if (accept) begin
            check("beat_expected", exp_d[g].size() > 0, 1'b1);
            if (exp_d[g].size() > 0) check("write_data", wdata[g], exp_d[g].pop_front());
            beats[g]++;
            left[g]--;
            if (left[g] == 0) pend[g] = 1'b1;
            held[g] = 1'b0;
          end else begin
            held[g]   = 1'b1;
            held_d[g] = wdata[g];
          end
        end else begin
          held[g] = 1'b0;
        end
        if (done[g] && !done_q[g]) begin
          rises[g]++;
          check("busy_low_at_done", busy[g], 0);
          check("all_bursts_sent", exp_a[g].size() + exp_d[g].size(), 0);
        end
        done_q[g] = done[g];
      end
    end
  end

  // Master model: burst_done one cycle after the last beat; optional random accept gaps
  initial begin
    accept = 1'b1;
    for (int g = 0; g < NI; g++) begin
      bdone[g] = 1'b0;
      pend[g]  = 1'b0;
    end
    forever begin
      @(posedge clk); #1;
      for (int g = 0; g < NI; g++) begin
        bdone[g] = pend[g] & rst_n;
        pend[g]  = 1'b0;
      end
      accept = rand_acc ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    for (int g = 0; g < NI; g++) done_q[g] = 1'b0;
    for (int k = 0; k < 16; k++) mem[k] = {32{8'(k)}};
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) check_reset(g);
    rst_n = 1'b1;

    // Pattern lines, accept tied high
    launch(32'h0000_1000);
    wait_all();

    // Random data, random accept gaps, ignored start mid-transfer
    fill_random();
    rand_acc = 1'b1;
    launch(32'h0000_1000);
    repeat (20) @(posedge clk);
    #1;
    base_addr = 32'h0000_8000;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    wait_all();

    // Restart after done at a fresh base
    fill_random();
    launch(32'h0002_0000);
    wait_all();

    // Reset during SEND_BLK of line 5, then restart from line 0
    launch(32'h0000_3000);
    n = 0;
    while (!(bursts[0] == 6 && wvalid[0]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_line5_send", bursts[0], 6);
    rst_n = 1'b0;
    #1;
    check_reset(0);
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      pend[g]   = 1'b0;
      held[g]   = 1'b0;
      done_q[g] = 1'b0;
    end
    rst_n = 1'b1;
    launch(32'h0000_1000);
    wait_all();

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
